vedic_div_12x6: RTL and testbench

- Iterative restoring divider; the inverse of the 6x6 multiplier path.
- Takes a 2*DW-bit dividend (e.g. a 12-bit product) and a DW-bit divisor, and returns a 2*DW-bit quotient and a DW-bit remainder.
- Computes one quotient bit per clock, behind a start/busy/done handshake.
- Used in the FFT datapath for normalisation and for checking multiplier results.

---
 rtl/vedic_div_12x6.sv | 101 ++++++++++
 tb/tb_vedic_div_12x6.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_div_12x6.sv
// Iterative restoring divider: 2*DW-bit dividend by DW-bit divisor, one quotient
// bit per clock behind a start/busy/done handshake. Inverse of the 6x6 multiplier path.
module vedic_div_12x6 #(
  parameter int DW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_zero
);

  localparam int CW = $clog2(2*DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(2*DW-1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DIVZ = 2'd2;

  logic [1:0]      state;
  logic [DW-1:0]   pr;
  logic [2*DW-1:0] dq;
  logic [DW-1:0]   dvsr;
  logic [CW-1:0]   cnt;

  logic [DW:0]     t;
  logic            ge;
  logic [DW-1:0]   pr_next;
  logic [2*DW-1:0] dq_next;

  // The stored remainder is always below the divisor, so it fits in DW bits;
  // the extra bit of the restoring step lives only in t during the compare.
  always_comb begin
    t       = {pr, dq[2*DW-1]};
    ge      = (t >= {1'b0, dvsr});
    pr_next = ge ? (t[DW-1:0] - dvsr) : t[DW-1:0];
    dq_next = {dq[2*DW-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      pr        <= '0;
      dq        <= '0;
      dvsr      <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dq    <= dividend;
            dvsr  <= divisor;
            pr    <= '0;
            cnt   <= CNT_LAST;
            busy  <= 1'b1;
            state <= (divisor == '0) ? DIVZ : RUN;
          end
        end
        RUN: begin
          pr <= pr_next;
          dq <= dq_next;
          if (cnt == '0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= dq_next;
            remainder <= pr_next;
            div_zero  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIVZ: begin
          // Saturated quotient; the low dividend bits are reported as remainder.
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          quotient  <= '1;
          remainder <= dq[DW-1:0];
          div_zero  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_div_12x6.sv
// Directed and random self-checking bench for vedic_div_12x6.
module tb_vedic_div_12x6;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] dividend;
  logic [5:0]  divisor;
  logic        busy;
  logic        done;
  logic [11:0] quotient;
  logic [5:0]  remainder;
  logic        div_zero;

  int vectors;
  int miscompares;

  vedic_div_12x6 #(.DW(6)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, waits (bounded) for done; reports results, latency,
  // busy-cycle count and whether outputs moved before done.
  task automatic do_div(input logic [11:0] dd, input logic [5:0] dv,
                        output logic [11:0] q, output logic [5:0] r, output logic dz,
                        output int lat, output int bcnt, output logic busy_at_done,
                        output logic moved);
    logic [11:0] q0;
    logic [5:0]  r0;
    logic        z0;
    q0 = quotient;
    r0 = remainder;
    z0 = div_zero;
    moved = 1'b0;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    step();
    start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (quotient !== q0 || remainder !== r0 || div_zero !== z0) moved = 1'b1;
      step();
      lat++;
    end
    q = quotient;
    r = remainder;
    dz = div_zero;
    busy_at_done = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    step();
    step();
    vectors++;
    if ({busy, done, quotient, remainder, div_zero} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got busy=%0b done=%0b q=%0d r=%0d dz=%0b expected all zero",
               busy, done, quotient, remainder, div_zero);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [11:0] q; logic [5:0] r; logic dz, bad, mv; int lat, bc;
    do_div(12'd100, 6'd7, q, r, dz, lat, bc, bad, mv);
    vectors++;
    if (q !== 12'd14) begin miscompares++; $display("[TB] FAIL basic_q: got %0d expected 14", q); end
    vectors++;
    if (r !== 6'd2) begin miscompares++; $display("[TB] FAIL basic_r: got %0d expected 2", r); end
    vectors++;
    if (dz !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_dz: got %0b expected 0", dz); end
    vectors++;
    if (lat != 12) begin miscompares++; $display("[TB] FAIL basic_latency: got %0d expected 12", lat); end
    vectors++;
    if (bc != 12) begin miscompares++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 12", bc); end
    vectors++;
    if (bad !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_busy_at_done: got %0b expected 0", bad); end
    step();
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_done_width: got %0b expected 0", done); end
    vectors++;
    if (quotient !== 12'd14) begin miscompares++; $display("[TB] FAIL basic_hold_q: got %0d expected 14", quotient); end
  endtask

  task automatic test_mult_inverse();
    logic [11:0] dds [3] = '{12'd4095, 12'd3969, 12'd4095};
    logic [5:0]  dvs [3] = '{6'd63, 6'd63, 6'd1};
    logic [11:0] eq  [3] = '{12'd65, 12'd63, 12'd4095};
    logic [11:0] q; logic [5:0] r; logic dz, bad, mv; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      do_div(dds[i], dvs[i], q, r, dz, lat, bc, bad, mv);
      vectors++;
      if (q !== eq[i]) begin miscompares++; $display("[TB] FAIL inv_q[%0d]: got %0d expected %0d", i, q, eq[i]); end
      vectors++;
      if (r !== 6'd0) begin miscompares++; $display("[TB] FAIL inv_r[%0d]: got %0d expected 0", i, r); end
      vectors++;
      if (lat != 12) begin miscompares++; $display("[TB] FAIL inv_latency[%0d]: got %0d expected 12", i, lat); end
    end
  endtask

  task automatic test_div_zero();
    logic [11:0] q; logic [5:0] r; logic dz, bad, mv; int lat, bc;
    do_div(12'h5A3, 6'd0, q, r, dz, lat, bc, bad, mv);
    vectors++;
    if (q !== 12'hFFF) begin miscompares++; $display("[TB] FAIL dz_q: got %h expected fff", q); end
    vectors++;
    if (r !== 6'h23) begin miscompares++; $display("[TB] FAIL dz_r: got %h expected 23", r); end
    vectors++;
    if (dz !== 1'b1) begin miscompares++; $display("[TB] FAIL dz_flag: got %0b expected 1", dz); end
    vectors++;
    if (lat != 1) begin miscompares++; $display("[TB] FAIL dz_latency: got %0d expected 1", lat); end
    vectors++;
    if (bc != 1) begin miscompares++; $display("[TB] FAIL dz_busy_cycles: got %0d expected 1", bc); end
    step();
    step();
    vectors++;
    if (div_zero !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL dz_hold: got dz=%0b done=%0b expected dz=1 done=0", div_zero, done);
    end
    do_div(12'd50, 6'd5, q, r, dz, lat, bc, bad, mv);
    vectors++;
    if ({q, r, dz} !== {12'd10, 6'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL dz_followup: got q=%0d r=%0d dz=%0b expected q=10 r=0 dz=0", q, r, dz);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [11:0] qmid;
    dividend = 12'd200;
    divisor  = 6'd9;
    start    = 1'b1;
    step();
    dividend = 12'd1000;
    divisor  = 6'd3;
    lat = 0;
    while (!done && lat < 40) begin step(); lat++; end
    vectors++;
    if (lat != 12) begin miscompares++; $display("[TB] FAIL b2b_first_latency: got %0d expected 12", lat); end
    vectors++;
    if (quotient !== 12'd22 || remainder !== 6'd2) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_result: got q=%0d r=%0d expected q=22 r=2", quotient, remainder);
    end
    step();
    start = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_accept: got done=%0b busy=%0b expected done=0 busy=1", done, busy);
    end
    lat = 0;
    qmid = 12'd0;
    while (!done && lat < 40) begin
      if (lat == 5) qmid = quotient;
      step();
      lat++;
    end
    vectors++;
    if (qmid !== 12'd22) begin miscompares++; $display("[TB] FAIL b2b_hold_during_run: got %0d expected 22", qmid); end
    vectors++;
    if (lat != 12) begin miscompares++; $display("[TB] FAIL b2b_second_latency: got %0d expected 12", lat); end
    vectors++;
    if (quotient !== 12'd333 || remainder !== 6'd1) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_result: got q=%0d r=%0d expected q=333 r=1", quotient, remainder);
    end
    step();
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_done_width: got %0b expected 0", done); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] q; logic [5:0] r; logic dz, bad, mv; int lat, bc;
    int dones;
    dividend = 12'd4000;
    divisor  = 6'd13;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    vectors++;
    if ({busy, done, quotient, remainder, div_zero} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got busy=%0b done=%0b q=%0d r=%0d dz=%0b expected all zero",
               busy, done, quotient, remainder, div_zero);
    end
    rst = 1'b0;
    dones = 0;
    repeat (15) begin step(); if (done) dones++; end
    vectors++;
    if (dones != 0) begin miscompares++; $display("[TB] FAIL midreset_no_done: got %0d pulses expected 0", dones); end
    do_div(12'd4000, 6'd13, q, r, dz, lat, bc, bad, mv);
    vectors++;
    if (q !== 12'd307 || r !== 6'd9 || lat != 12) begin
      miscompares++;
      $display("[TB] FAIL midreset_rerun: got q=%0d r=%0d lat=%0d expected q=307 r=9 lat=12", q, r, lat);
    end
  endtask

  task automatic test_random();
    logic [11:0] q, dd, eq; logic [5:0] r, dv, er; logic dz, bad, mv; int lat, bc, mode, elat;
    for (int n = 0; n < 1000; n++) begin
      mode = $urandom_range(0, 3);
      dv = (mode == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      dd = (mode == 1) ? 12'($urandom_range(0, int'(dv) - 1)) : 12'($urandom_range(0, 4095));
      eq   = (dv == 0) ? 12'hFFF : dd / {6'd0, dv};
      er   = (dv == 0) ? dd[5:0] : 6'(dd % {6'd0, dv});
      elat = (dv == 0) ? 1 : 12;
      do_div(dd, dv, q, r, dz, lat, bc, bad, mv);
      vectors++;
      if (q !== eq || r !== er || dz !== (dv == 0)) begin
        miscompares++;
        $display("[TB] FAIL rand_result: %0d/%0d got q=%0d r=%0d dz=%0b expected q=%0d r=%0d", dd, dv, q, r, dz, eq, er);
      end
      if (dv != 0) begin
        vectors++;
        if (32'(q) * 32'(dv) + 32'(r) != 32'(dd) || r >= dv) begin
          miscompares++;
          $display("[TB] FAIL rand_invariant: %0d/%0d got q=%0d r=%0d", dd, dv, q, r);
        end
      end
      vectors++;
      if (lat != elat) begin miscompares++; $display("[TB] FAIL rand_latency: got %0d expected %0d", lat, elat); end
      vectors++;
      if (mv !== 1'b0) begin miscompares++; $display("[TB] FAIL rand_stability: outputs changed before done, got 1 expected 0"); end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    test_reset();
    test_basic();
    test_mult_inverse();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
